// File: rtl/control_sequencer_pkg.sv
// Shared types for the control sequencer: opcode map, FSM states and the
// decoded control word that fans out to the datapath.
package ctrl_pkg;

  localparam int OPCODE_W = 6;

  // Single-cycle (EXEC-commit) class
  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_ADD   = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_OR    = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h05;
  localparam logic [5:0] OP_MOV   = 6'h06;
  localparam logic [5:0] OP_LDI   = 6'h07;
  localparam logic [5:0] OP_JMP   = 6'h08;
  localparam logic [5:0] OP_BEQZ  = 6'h09;
  // Memory class (commit in MEM after handshake)
  localparam logic [5:0] OP_LOAD  = 6'h10;
  localparam logic [5:0] OP_STORE = 6'h11;
  localparam logic [5:0] OP_PUSH  = 6'h12;
  localparam logic [5:0] OP_POP   = 6'h13;
  localparam logic [5:0] OP_CALL  = 6'h14;
  localparam logic [5:0] OP_RET   = 6'h15;
  localparam logic [5:0] OP_HALT  = 6'h20;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctl_t;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_IMM  = 2'd1,
    PC_REG  = 2'd2,
    PC_HOLD = 2'd3
  } pc_ctl_t;

  localparam logic [1:0] SRC2_REG = 2'd0;
  localparam logic [1:0] SRC2_IMM = 2'd1;
  localparam logic [1:0] SRC2_ONE = 2'd2;

  localparam logic [1:0] RES_MEM = 2'd0;
  localparam logic [1:0] RES_ALU = 2'd1;
  localparam logic [1:0] RES_REG = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       stack_control;
    logic       pc_increment_control;
    pc_ctl_t    pc_control;
    logic       gr_we;
    logic       stack_we;
    logic       write_data_enable;
    logic [1:0] alu_src2;
    alu_ctl_t   alu_ctl;
    logic       branch;
    logic [1:0] result_sel;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NONE = '0;

endpackage

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode decoder: opcode -> control word plus class flags.
// Strobes here are raw; the sequencer qualifies them with its state.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          cw,
  output logic                is_mem,
  output logic                is_halt,
  output logic                illegal
);

  always_comb begin
    cw      = CW_NONE;
    is_halt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin cw.gr_we = 1'b1; cw.result_sel = RES_ALU; end
      OP_SUB: begin cw.gr_we = 1'b1; cw.result_sel = RES_ALU; cw.alu_ctl = ALU_SUB; end
      OP_AND: begin cw.gr_we = 1'b1; cw.result_sel = RES_ALU; cw.alu_ctl = ALU_AND; end
      OP_OR:  begin cw.gr_we = 1'b1; cw.result_sel = RES_ALU; cw.alu_ctl = ALU_OR;  end
      OP_ADDI: begin
        cw.gr_we = 1'b1; cw.result_sel = RES_ALU; cw.alu_src2 = SRC2_IMM;
        cw.pc_increment_control = 1'b1;
      end
      OP_MOV: begin cw.gr_we = 1'b1; cw.result_sel = RES_REG; end
      OP_LDI: begin
        cw.gr_we = 1'b1; cw.result_sel = RES_IMM; cw.pc_increment_control = 1'b1;
      end
      OP_JMP:  begin cw.pc_control = PC_IMM; cw.pc_increment_control = 1'b1; end
      OP_BEQZ: begin cw.branch = 1'b1; cw.pc_increment_control = 1'b1; end
      OP_LOAD: begin cw.mem_req = 1'b1; cw.gr_we = 1'b1; cw.result_sel = RES_MEM; end
      OP_STORE: begin cw.mem_req = 1'b1; cw.mem_write = 1'b1; end
      // Stack ops move SP through the ALU with the constant-one operand
      OP_PUSH: begin
        cw.mem_req = 1'b1; cw.mem_write = 1'b1; cw.stack_control = 1'b1;
        cw.stack_we = 1'b1; cw.alu_src2 = SRC2_ONE; cw.alu_ctl = ALU_SUB;
      end
      OP_POP: begin
        cw.mem_req = 1'b1; cw.stack_we = 1'b1; cw.gr_we = 1'b1;
        cw.result_sel = RES_MEM; cw.alu_src2 = SRC2_ONE;
      end
      OP_CALL: begin
        cw.mem_req = 1'b1; cw.mem_write = 1'b1; cw.stack_control = 1'b1;
        cw.stack_we = 1'b1; cw.write_data_enable = 1'b1; cw.pc_control = PC_IMM;
        cw.pc_increment_control = 1'b1; cw.alu_src2 = SRC2_ONE; cw.alu_ctl = ALU_SUB;
      end
      OP_RET: begin
        cw.mem_req = 1'b1; cw.stack_we = 1'b1; cw.pc_control = PC_REG;
        cw.alu_src2 = SRC2_ONE;
      end
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
    is_mem = cw.mem_req;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/HALT control FSM driving the datapath controls.
// Strobes and pc_control are live only in the commit cycle; PC holds otherwise.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             stack_control,
  output logic             pc_increment_control,
  output logic [1:0]       pc_control,
  output logic             general_register_write_enable,
  output logic             stack_write_enable,
  output logic             write_data_enable,
  output logic [1:0]       ALU_soure_2,
  output logic [1:0]       ALU_control,
  output logic             branch,
  output logic [1:0]       general_register_result_select,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired_count
);

  localparam int                TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_write_q, mem_write_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_word_t cw;
  logic       is_mem, is_halt, illegal, commit;
  logic       unused_operand;

  // Operand fields are consumed by the datapath, not by the sequencer
  assign unused_operand = ^ir_q[15-OPCODE_W:0];

  ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (ir_q[15 -: OPCODE_W]),
    .cw      (cw),
    .is_mem  (is_mem),
    .is_halt (is_halt),
    .illegal (illegal)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    error_d     = error_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    case (state_q)
      FETCH: begin
        ir_d    = instr;
        state_d = EXEC;
      end
      EXEC: begin
        if (illegal) begin
          state_d = HALT;
          error_d = 1'b1;
        end else if (is_halt) begin
          state_d = HALT;
          cnt_d   = cnt_q + 1'b1;
        end else if (is_mem) begin
          state_d     = MEM;
          mem_req_d   = 1'b1;
          mem_write_d = cw.mem_write;
          tmo_d       = '0;
        end else begin
          commit  = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        if (mem_ready) begin
          commit      = 1'b1;
          state_d     = FETCH;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = HALT;
          error_d     = 1'b1;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (commit) cnt_d = cnt_q + 1'b1;
  end

  // Datapath selects stay valid for the whole MEM phase so address and write
  // data are stable under the request; strobes fire only on commit.
  always_comb begin
    pc_control                     = PC_HOLD;
    general_register_write_enable  = 1'b0;
    stack_write_enable             = 1'b0;
    branch                         = 1'b0;
    pc_increment_control           = 1'b0;
    stack_control                  = 1'b0;
    write_data_enable              = 1'b0;
    ALU_soure_2                    = SRC2_REG;
    ALU_control                    = ALU_ADD;
    general_register_result_select = RES_MEM;
    if (commit || state_q == MEM) begin
      stack_control                  = cw.stack_control;
      write_data_enable              = cw.write_data_enable;
      ALU_soure_2                    = cw.alu_src2;
      ALU_control                    = cw.alu_ctl;
      general_register_result_select = cw.result_sel;
    end
    if (commit) begin
      pc_control                    = cw.pc_control;
      general_register_write_enable = cw.gr_we;
      stack_write_enable            = cw.stack_we;
      branch                        = cw.branch;
      pc_increment_control          = cw.pc_increment_control;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_write     = mem_write_q;
  assign halted        = (state_q == HALT);
  assign error         = error_q;
  assign retired_count = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      ir_q        <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized instruction-level bench for control_sequencer: two instances
// (16-bit and 2-bit retired counter, MEM_TIMEOUT=4) driven in lockstep.
module tb_control_sequencer;

  localparam int TMO = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       stack_control;
    logic       pc_inc;
    logic [1:0] pc;
    logic       gwe;
    logic       swe;
    logic       wde;
    logic [1:0] src2;
    logic [1:0] alu;
    logic       branch;
    logic [1:0] rsel;
    logic       halted;
    logic       error;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        mem_ready = 1'b0;

  logic a_mem_req, a_mem_write, a_sc, a_pc_inc, a_gwe, a_swe, a_wde, a_branch, a_halted, a_error;
  logic b_mem_req, b_mem_write, b_sc, b_pc_inc, b_gwe, b_swe, b_wde, b_branch, b_halted, b_error;
  logic [1:0] a_pc, a_src2, a_alu, a_rsel, b_pc, b_src2, b_alu, b_rsel;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;
  obs_t obs_a, obs_b;

  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  control_sequencer #(.OPCODE_W(6), .CNT_W(16), .MEM_TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .stack_control(a_sc),
    .pc_increment_control(a_pc_inc), .pc_control(a_pc),
    .general_register_write_enable(a_gwe), .stack_write_enable(a_swe),
    .write_data_enable(a_wde), .ALU_soure_2(a_src2), .ALU_control(a_alu),
    .branch(a_branch), .general_register_result_select(a_rsel),
    .halted(a_halted), .error(a_error), .retired_count(a_cnt)
  );

  control_sequencer #(.OPCODE_W(6), .CNT_W(2), .MEM_TIMEOUT(TMO)) u_dut_w2 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .stack_control(b_sc),
    .pc_increment_control(b_pc_inc), .pc_control(b_pc),
    .general_register_write_enable(b_gwe), .stack_write_enable(b_swe),
    .write_data_enable(b_wde), .ALU_soure_2(b_src2), .ALU_control(b_alu),
    .branch(b_branch), .general_register_result_select(b_rsel),
    .halted(b_halted), .error(b_error), .retired_count(b_cnt)
  );

  assign obs_a = {a_mem_req, a_mem_write, a_sc, a_pc_inc, a_pc, a_gwe, a_swe, a_wde,
                  a_src2, a_alu, a_branch, a_rsel, a_halted, a_error};
  assign obs_b = {b_mem_req, b_mem_write, b_sc, b_pc_inc, b_pc, b_gwe, b_swe, b_wde,
                  b_src2, b_alu, b_branch, b_rsel, b_halted, b_error};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // 0 = commits in EXEC, 1 = memory handshake, 2 = HALT opcode, 3 = undefined
  function automatic int kind(input logic [5:0] op);
    if (op <= 6'h09) return 0;
    if (op >= 6'h10 && op <= 6'h15) return 1;
    if (op == 6'h20) return 2;
    return 3;
  endfunction

  function automatic obs_t idle_o(input logic h, input logic e);
    obs_t o = '0;
    o.pc = 2'd3; o.halted = h; o.error = e;
    return o;
  endfunction

  // Fields the datapath may rely on in a non-commit cycle
  function automatic obs_t nc_mask();
    obs_t m = '0;
    m.mem_req = 1; m.mem_write = 1; m.pc = 2'b11; m.gwe = 1; m.swe = 1;
    m.branch = 1; m.halted = 1; m.error = 1;
    return m;
  endfunction

  // Required outputs in the commit cycle of each instruction
  function automatic obs_t ref_commit(input logic [5:0] op);
    obs_t o = '0;
    case (op)
      6'h01: begin o.gwe = 1; o.rsel = 1; end                              // ADD
      6'h02: begin o.gwe = 1; o.rsel = 1; o.alu = 1; end                   // SUB
      6'h03: begin o.gwe = 1; o.rsel = 1; o.alu = 2; end                   // AND
      6'h04: begin o.gwe = 1; o.rsel = 1; o.alu = 3; end                   // OR
      6'h05: begin o.gwe = 1; o.rsel = 1; o.src2 = 1; o.pc_inc = 1; end    // ADDI
      6'h06: begin o.gwe = 1; o.rsel = 2; end                              // MOV
      6'h07: begin o.gwe = 1; o.rsel = 3; o.pc_inc = 1; end                // LDI
      6'h08: begin o.pc = 1; o.pc_inc = 1; end                             // JMP
      6'h09: begin o.branch = 1; o.pc_inc = 1; end                         // BEQZ
      6'h10: begin o.mem_req = 1; o.gwe = 1; end                           // LOAD
      6'h11: begin o.mem_req = 1; o.mem_write = 1; end                     // STORE
      6'h12: begin o.mem_req = 1; o.mem_write = 1; o.stack_control = 1;    // PUSH
                   o.swe = 1; o.src2 = 2; o.alu = 1; end
      6'h13: begin o.mem_req = 1; o.swe = 1; o.gwe = 1; o.src2 = 2; end    // POP
      6'h14: begin o.mem_req = 1; o.mem_write = 1; o.stack_control = 1;    // CALL
                   o.swe = 1; o.wde = 1; o.pc = 1; o.pc_inc = 1;
                   o.src2 = 2; o.alu = 1; end
      6'h15: begin o.mem_req = 1; o.swe = 1; o.pc = 2; o.src2 = 2; end     // RET
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle's inputs, check both instances, advance past the edge
  task automatic cycle(input obs_t exp, input obs_t msk, input logic rdy);
    mem_ready = rdy;
    #2;
    chk("outs", 32'(obs_a & msk), 32'(exp & msk));
    chk("outs_w2", 32'(obs_b & msk), 32'(exp & msk));
    chk("count", 32'(a_cnt), 32'(model_cnt % 65536));
    chk("count_w2", 32'(b_cnt), 32'(model_cnt % 4));
    @(posedge clk);
    #1;
    instr = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_outs", 32'(obs_a), 32'(idle_o(1'b0, 1'b0)));
    chk("rst_outs_w2", 32'(obs_b), 32'(idle_o(1'b0, 1'b0)));
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_count_w2", 32'(b_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_cnt = 0;
  endtask

  task automatic halt_check(input logic e);
    repeat (2) cycle(idle_o(1'b1, e), nc_mask(), 1'($urandom));
    do_reset();
  endtask

  task automatic run_instr(input logic [5:0] op, input int wait_n, input int rst_at);
    obs_t c, w, all1;
    int   k;
    k = kind(op);
    c = ref_commit(op);
    w = idle_o(1'b0, 1'b0);
    w.mem_req = 1'b1;
    w.mem_write = c.mem_write;
    all1 = '1;
    instr = {op, 10'($urandom)};
    cycle(idle_o(1'b0, 1'b0), nc_mask(), 1'($urandom));       // FETCH
    if (k == 0) begin
      cycle(c, all1, 1'($urandom));
      model_cnt++;
      return;
    end
    cycle(idle_o(1'b0, 1'b0), nc_mask(), 1'($urandom));       // EXEC, no commit
    if (k == 2) begin
      model_cnt++;
      halt_check(1'b0);
      return;
    end
    if (k == 3) begin
      halt_check(1'b1);
      return;
    end
    for (int i = 0; i < TMO; i++) begin
      if (i == rst_at) begin
        mem_ready = 1'b0;
        #2;
        chk("pre_rst_req", 32'(a_mem_req), 32'd1);
        do_reset();
        return;
      end
      if (i == wait_n) begin
        cycle(c, all1, 1'b1);
        model_cnt++;
        return;
      end
      cycle(w, nc_mask(), 1'b0);
    end
    halt_check(1'b1);
  endtask

  function automatic logic [5:0] pick_op();
    int r;
    logic [5:0] op;
    r = $urandom_range(99);
    if (r < 45) return 6'($urandom_range(9));
    if (r < 88) return 6'h10 + 6'($urandom_range(5));
    if (r < 93) return 6'h20;
    do op = 6'($urandom); while (kind(op) != 3);
    return op;
  endfunction

  initial begin
    int wn, ra;
    do_reset();
    run_instr(6'h01, 0, -1);      // ADD
    run_instr(6'h00, 0, -1);      // NOP
    run_instr(6'h10, 3, -1);      // LOAD, ready after 3 waits
    run_instr(6'h11, 99, -1);     // STORE, timeout
    run_instr(6'h3F, 0, -1);      // undefined opcode
    run_instr(6'h20, 0, -1);      // HALT opcode
    run_instr(6'h10, 99, 2);      // reset mid-MEM
    repeat (5) run_instr(6'h00, 0, -1);
    run_instr(6'h14, 0, -1);      // CALL, ready on MEM entry
    for (int n = 0; n < 300; n++) begin
      wn = ($urandom_range(9) < 2) ? TMO : int'($urandom_range(TMO - 1));
      ra = ($urandom_range(19) == 0) ? int'($urandom_range(TMO - 1)) : -1;
      run_instr(pick_op(), wn, ra);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
